pipe_id_ex: RTL and testbench

ID/EX pipeline register with load-use hazard detection, write-back bypass and EX-stage operand forwarding. It sits between instruction decode and `pipe_alu`. It captures decoded fields on each clock and resolves operand hazards, so the ALU always receives correct `DataIn1`/`DataIn2`/`AluCtrl`/`offset`/`bne` values. It also inserts bubbles on load-use stalls and on branch flushes.

---
 rtl/ctrl_encode_def.sv | 45 ++++
 rtl/pipe_fwd_mux.sv | 33 +++
 rtl/pipe_id_ex.sv | 170 +++++++++++++++++
 tb/tb_pipe_id_ex.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_encode_def.sv
// Shared control encodings: ALUOp codes and the EX-stage control bundle.
// The bubble constant is the all-quiet control word loaded on stalls and flushes.
package ctrl_encode_def;

  localparam logic [4:0] ALUOp_nop  = 5'd0;
  localparam logic [4:0] ALUOp_lui  = 5'd1;
  localparam logic [4:0] ALUOp_add  = 5'd2;
  localparam logic [4:0] ALUOp_addu = 5'd3;
  localparam logic [4:0] ALUOp_sub  = 5'd4;
  localparam logic [4:0] ALUOp_subu = 5'd5;
  localparam logic [4:0] ALUOp_and  = 5'd6;
  localparam logic [4:0] ALUOp_or   = 5'd7;
  localparam logic [4:0] ALUOp_xor  = 5'd8;
  localparam logic [4:0] ALUOp_nor  = 5'd9;
  localparam logic [4:0] ALUOp_slt  = 5'd10;
  localparam logic [4:0] ALUOp_sltu = 5'd11;
  localparam logic [4:0] ALUOp_sll  = 5'd12;
  localparam logic [4:0] ALUOp_srl  = 5'd13;
  localparam logic [4:0] ALUOp_sra  = 5'd14;

  typedef struct packed {
    logic       valid;
    logic       bne;
    logic       branch;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic [4:0] aluctrl;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '{
    valid:    1'b0,
    bne:      1'b0,
    branch:   1'b0,
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    alusrc:   1'b0,
    aluctrl:  ALUOp_nop
  };

endpackage

// File: rtl/pipe_fwd_mux.sv
// Three-way priority operand selector: EX/MEM result, then MEM/WB data, then
// the value captured in the ID/EX register. Register 0 is never forwarded.
module pipe_fwd_mux #(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic [RA-1:0] src_reg,
  input  logic [W-1:0]  src_data,
  input  logic          exm_regwrite,
  input  logic [RA-1:0] exm_wreg,
  input  logic [W-1:0]  exm_result,
  input  logic          mwb_regwrite,
  input  logic [RA-1:0] mwb_wreg,
  input  logic [W-1:0]  mwb_wdata,
  output logic [W-1:0]  fwd_data
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_regwrite && (exm_wreg != '0) && (exm_wreg == src_reg);
  assign mwb_hit = mwb_regwrite && (mwb_wreg != '0) && (mwb_wreg == src_reg);

  // The younger producer (EX/MEM) must shadow the older one.
  always_comb begin
    fwd_data = src_data;
    if (exm_hit)
      fwd_data = exm_result;
    else if (mwb_hit)
      fwd_data = mwb_wdata;
  end

endmodule

// File: rtl/pipe_id_ex.sv
// ID/EX pipeline register: load-use stall detection, write-back bypass at capture,
// and combinational EX-stage forwarding onto the ALU operand buses.
module pipe_id_ex
  import ctrl_encode_def::*;
#(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [W-1:0]  id_rdata1,
  input  logic [W-1:0]  id_rdata2,
  input  logic [W-1:0]  id_imm,
  input  logic [5:0]    id_shamt,
  input  logic [4:0]    id_aluctrl,
  input  logic          id_alusrc,
  input  logic          id_bne,
  input  logic          id_branch,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic [RA-1:0] id_wreg,
  input  logic          flush,
  input  logic          exm_regwrite,
  input  logic [RA-1:0] exm_wreg,
  input  logic [W-1:0]  exm_result,
  input  logic          mwb_regwrite,
  input  logic [RA-1:0] mwb_wreg,
  input  logic [W-1:0]  mwb_wdata,
  output logic          stall,
  output logic [W-1:0]  alu_in1,
  output logic [W-1:0]  alu_in2,
  output logic [4:0]    alu_ctrl,
  output logic [5:0]    alu_offset,
  output logic          alu_bne,
  output logic [W-1:0]  ex_store_data,
  output logic          ex_valid,
  output logic          ex_branch,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic [RA-1:0] ex_wreg,
  output logic [W-1:0]  ex_imm
);

  ex_ctrl_t      ctrl_q;
  logic [RA-1:0] rs_q;
  logic [RA-1:0] rt_q;
  logic [RA-1:0] wreg_q;
  logic [W-1:0]  rdata1_q;
  logic [W-1:0]  rdata2_q;
  logic [W-1:0]  imm_q;
  logic [5:0]    shamt_q;

  logic          hit_rs;
  logic          hit_rt;
  logic          load_bubble;
  logic [W-1:0]  byp_rdata1;
  logic [W-1:0]  byp_rdata2;
  logic [W-1:0]  fwd_rs;
  logic [W-1:0]  fwd_rt;
  ex_ctrl_t      id_ctrl;

  assign hit_rs = id_use_rs && (id_rs == wreg_q);
  assign hit_rt = id_use_rt && (id_rt == wreg_q);

  // A load in EX cannot feed ID yet; flush outranks it since ID is being killed anyway.
  assign stall = ctrl_q.valid && ctrl_q.memread && (wreg_q != '0) &&
                 (hit_rs || hit_rt) && !flush;

  assign load_bubble = flush || stall || !id_valid;

  // The register file is not write-through, so a same-cycle write must be picked up here.
  assign byp_rdata1 = (mwb_regwrite && (mwb_wreg != '0) && (mwb_wreg == id_rs)) ?
                      mwb_wdata : id_rdata1;
  assign byp_rdata2 = (mwb_regwrite && (mwb_wreg != '0) && (mwb_wreg == id_rt)) ?
                      mwb_wdata : id_rdata2;

  assign id_ctrl = '{
    valid:    1'b1,
    bne:      id_bne,
    branch:   id_branch,
    regwrite: id_regwrite,
    memread:  id_memread,
    memwrite: id_memwrite,
    memtoreg: id_memtoreg,
    alusrc:   id_alusrc,
    aluctrl:  id_aluctrl
  };

  // Unused source numbers are stored as r0 so they can never trigger a forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_BUBBLE;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
    end else if (load_bubble) begin
      ctrl_q   <= CTRL_BUBBLE;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      shamt_q  <= '0;
    end else begin
      ctrl_q   <= id_ctrl;
      rs_q     <= id_use_rs ? id_rs : '0;
      rt_q     <= id_use_rt ? id_rt : '0;
      wreg_q   <= id_wreg;
      rdata1_q <= byp_rdata1;
      rdata2_q <= byp_rdata2;
      imm_q    <= id_imm;
      shamt_q  <= id_shamt;
    end
  end

  pipe_fwd_mux #(.W(W), .RA(RA)) u_fwd_rs (
    .src_reg      (rs_q),
    .src_data     (rdata1_q),
    .exm_regwrite (exm_regwrite),
    .exm_wreg     (exm_wreg),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_wreg     (mwb_wreg),
    .mwb_wdata    (mwb_wdata),
    .fwd_data     (fwd_rs)
  );

  pipe_fwd_mux #(.W(W), .RA(RA)) u_fwd_rt (
    .src_reg      (rt_q),
    .src_data     (rdata2_q),
    .exm_regwrite (exm_regwrite),
    .exm_wreg     (exm_wreg),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_wreg     (mwb_wreg),
    .mwb_wdata    (mwb_wdata),
    .fwd_data     (fwd_rt)
  );

  assign alu_in1       = fwd_rs;
  assign alu_in2       = ctrl_q.alusrc ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_ctrl      = ctrl_q.aluctrl;
  assign alu_offset    = shamt_q;
  assign alu_bne       = ctrl_q.valid && ctrl_q.bne;

  assign ex_valid    = ctrl_q.valid;
  assign ex_branch   = ctrl_q.branch;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_wreg     = wreg_q;
  assign ex_imm      = imm_q;

endmodule

// File: tb/tb_pipe_id_ex.sv
// Directed bench for pipe_id_ex: capture, forwarding priority, load-use stall,
// flush, write-back bypass and asynchronous reset, with hand-computed expectations.
module tb_pipe_id_ex;
  import ctrl_encode_def::*;

  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RA-1:0] id_rs, id_rt;
  logic          id_use_rs, id_use_rt;
  logic [W-1:0]  id_rdata1, id_rdata2, id_imm;
  logic [5:0]    id_shamt;
  logic [4:0]    id_aluctrl;
  logic          id_alusrc, id_bne, id_branch, id_regwrite;
  logic          id_memread, id_memwrite, id_memtoreg;
  logic [RA-1:0] id_wreg;
  logic          flush;
  logic          exm_regwrite;
  logic [RA-1:0] exm_wreg;
  logic [W-1:0]  exm_result;
  logic          mwb_regwrite;
  logic [RA-1:0] mwb_wreg;
  logic [W-1:0]  mwb_wdata;
  logic          stall;
  logic [W-1:0]  alu_in1, alu_in2, ex_store_data, ex_imm;
  logic [4:0]    alu_ctrl;
  logic [5:0]    alu_offset;
  logic          alu_bne;
  logic          ex_valid, ex_branch, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic [RA-1:0] ex_wreg;

  int checks = 0;
  int errors = 0;

  pipe_id_ex #(.W(W), .RA(RA)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_aluctrl(id_aluctrl), .id_alusrc(id_alusrc),
    .id_bne(id_bne), .id_branch(id_branch), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_wreg(id_wreg), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_wreg(exm_wreg), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_wreg(mwb_wreg), .mwb_wdata(mwb_wdata),
    .stall(stall), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_offset(alu_offset), .alu_bne(alu_bne), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_wreg(ex_wreg), .ex_imm(ex_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_shamt = '0;
    id_aluctrl = ALUOp_nop; id_alusrc = 0; id_bne = 0; id_branch = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_wreg = '0; flush = 0;
    exm_regwrite = 0; exm_wreg = '0; exm_result = '0;
    mwb_regwrite = 0; mwb_wreg = '0; mwb_wdata = '0;
  endtask

  task automatic drive_rtype(input logic [4:0] op, input logic [RA-1:0] rs,
                             input logic [RA-1:0] rt, input logic [RA-1:0] rd,
                             input logic [W-1:0] d1, input logic [W-1:0] d2);
    id_valid = 1; id_rs = rs; id_rt = rt; id_use_rs = 1; id_use_rt = 1;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = '0; id_shamt = '0;
    id_aluctrl = op; id_alusrc = 0; id_bne = 0; id_branch = 0;
    id_regwrite = 1; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_wreg = rd;
  endtask

  task automatic drive_load(input logic [RA-1:0] base, input logic [RA-1:0] rt,
                            input logic [W-1:0] d1, input logic [W-1:0] off);
    id_valid = 1; id_rs = base; id_rt = rt; id_use_rs = 1; id_use_rt = 0;
    id_rdata1 = d1; id_rdata2 = '0; id_imm = off; id_shamt = '0;
    id_aluctrl = ALUOp_addu; id_alusrc = 1; id_bne = 0; id_branch = 0;
    id_regwrite = 1; id_memread = 1; id_memwrite = 0; id_memtoreg = 1;
    id_wreg = rt;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid: got %b expected 0", ex_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (alu_in1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_alu_in1: got %h expected 0", alu_in1); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_addu();
    @(negedge clk);
    drive_rtype(ALUOp_addu, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    id_shamt = 6'd3;
    tick();
    checks++; if (alu_in1 !== 32'd5) begin errors++; $display("[TB] FAIL addu_in1: got %h expected 5", alu_in1); end
    checks++; if (alu_in2 !== 32'd7) begin errors++; $display("[TB] FAIL addu_in2: got %h expected 7", alu_in2); end
    checks++; if (alu_ctrl !== ALUOp_addu) begin errors++; $display("[TB] FAIL addu_ctrl: got %h expected %h", alu_ctrl, ALUOp_addu); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL addu_valid: got %b expected 1", ex_valid); end
    checks++; if (ex_wreg !== 5'd3) begin errors++; $display("[TB] FAIL addu_wreg: got %0d expected 3", ex_wreg); end
    checks++; if (ex_regwrite !== 1'b1) begin errors++; $display("[TB] FAIL addu_regwrite: got %b expected 1", ex_regwrite); end
    checks++; if (alu_offset !== 6'd3) begin errors++; $display("[TB] FAIL addu_offset: got %0d expected 3", alu_offset); end
  endtask

  task automatic test_forward_priority();
    exm_regwrite = 1; exm_wreg = 5'd1; exm_result = 32'h10;
    mwb_regwrite = 1; mwb_wreg = 5'd1; mwb_wdata = 32'h20;
    #1;
    checks++; if (alu_in1 !== 32'h10) begin errors++; $display("[TB] FAIL fwd_exm_wins: got %h expected 10", alu_in1); end
    exm_regwrite = 0;
    #1;
    checks++; if (alu_in1 !== 32'h20) begin errors++; $display("[TB] FAIL fwd_mwb: got %h expected 20", alu_in1); end
    exm_regwrite = 1; exm_wreg = 5'd2; exm_result = 32'h33;
    #1;
    checks++; if (alu_in2 !== 32'h33) begin errors++; $display("[TB] FAIL fwd_rt_exm: got %h expected 33", alu_in2); end
    checks++; if (alu_in1 !== 32'h20) begin errors++; $display("[TB] FAIL fwd_rs_indep: got %h expected 20", alu_in1); end
    mwb_regwrite = 0; exm_regwrite = 0;
    #1;
    checks++; if (alu_in1 !== 32'd5) begin errors++; $display("[TB] FAIL fwd_none: got %h expected 5", alu_in1); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    drive_load(5'd1, 5'd4, 32'h100, 32'h8);
    tick();
    checks++; if (ex_memread !== 1'b1) begin errors++; $display("[TB] FAIL lw_memread: got %b expected 1", ex_memread); end
    checks++; if (alu_in2 !== 32'h8) begin errors++; $display("[TB] FAIL lw_in2_imm: got %h expected 8", alu_in2); end
    @(negedge clk);
    drive_rtype(ALUOp_sub, 5'd4, 5'd1, 5'd5, 32'h0, 32'd5);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall: got %b expected 1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_valid: got %b expected 0", ex_valid); end
    checks++; if (alu_ctrl !== ALUOp_nop) begin errors++; $display("[TB] FAIL lu_bubble_ctrl: got %h expected 0", alu_ctrl); end
    checks++; if (ex_wreg !== 5'd0) begin errors++; $display("[TB] FAIL lu_bubble_wreg: got %0d expected 0", ex_wreg); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_regwrite: got %b expected 0", ex_regwrite); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_falls: got %b expected 0", stall); end
    exm_regwrite = 1; exm_wreg = 5'd4; exm_result = 32'h108;
    tick();
    exm_regwrite = 0; exm_wreg = '0;
    mwb_regwrite = 1; mwb_wreg = 5'd4; mwb_wdata = 32'h77;
    #1;
    checks++; if (alu_in1 !== 32'h77) begin errors++; $display("[TB] FAIL lu_sub_in1: got %h expected 77", alu_in1); end
    checks++; if (alu_in2 !== 32'd5) begin errors++; $display("[TB] FAIL lu_sub_in2: got %h expected 5", alu_in2); end
    checks++; if (alu_ctrl !== ALUOp_sub) begin errors++; $display("[TB] FAIL lu_sub_ctrl: got %h expected %h", alu_ctrl, ALUOp_sub); end
    checks++; if (ex_wreg !== 5'd5) begin errors++; $display("[TB] FAIL lu_sub_wreg: got %0d expected 5", ex_wreg); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    clear_inputs();
    drive_load(5'd2, 5'd6, 32'h200, 32'h4);
    tick();
    @(negedge clk);
    drive_rtype(ALUOp_addu, 5'd1, 5'd6, 5'd7, 32'h1, 32'h2);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_stall: got %b expected 1", stall); end
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b expected 0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", ex_valid); end
    checks++; if (ex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL flush_regwrite: got %b expected 0", ex_regwrite); end
    flush = 0;
  endtask

  task automatic test_wb_bypass();
    @(negedge clk);
    clear_inputs();
    id_valid = 1; id_rs = 5'd1; id_rt = 5'd2; id_use_rs = 1; id_use_rt = 1;
    id_rdata1 = 32'h40; id_rdata2 = 32'h0; id_imm = 32'h4; id_alusrc = 1;
    id_memwrite = 1; id_aluctrl = ALUOp_addu;
    mwb_regwrite = 1; mwb_wreg = 5'd2; mwb_wdata = 32'hABCD;
    tick();
    mwb_regwrite = 0; mwb_wreg = '0; mwb_wdata = '0;
    #1;
    checks++; if (ex_store_data !== 32'hABCD) begin errors++; $display("[TB] FAIL byp_store: got %h expected abcd", ex_store_data); end
    checks++; if (alu_in2 !== 32'h4) begin errors++; $display("[TB] FAIL byp_in2_imm: got %h expected 4", alu_in2); end
    checks++; if (ex_memwrite !== 1'b1) begin errors++; $display("[TB] FAIL byp_memwrite: got %b expected 1", ex_memwrite); end
    @(negedge clk);
    id_rs = 5'd0; id_rt = 5'd0; id_rdata1 = 32'h0; id_rdata2 = 32'h0;
    mwb_regwrite = 1; mwb_wreg = 5'd0; mwb_wdata = 32'h1234;
    tick();
    exm_regwrite = 1; exm_wreg = 5'd0; exm_result = 32'h999;
    #1;
    checks++; if (ex_store_data !== 32'h0) begin errors++; $display("[TB] FAIL r0_store: got %h expected 0", ex_store_data); end
    checks++; if (alu_in1 !== 32'h0) begin errors++; $display("[TB] FAIL r0_in1: got %h expected 0", alu_in1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clear_inputs();
    drive_rtype(ALUOp_or, 5'd8, 5'd9, 5'd10, 32'h11, 32'h22);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre_valid: got %b expected 1", ex_valid); end
    #2;
    rst_n = 0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid: got %b expected 0", ex_valid); end
    checks++; if (alu_in1 !== 32'h0) begin errors++; $display("[TB] FAIL ar_in1: got %h expected 0", alu_in1); end
    checks++; if (alu_ctrl !== 5'd0) begin errors++; $display("[TB] FAIL ar_ctrl: got %h expected 0", alu_ctrl); end
    checks++; if (ex_wreg !== 5'd0) begin errors++; $display("[TB] FAIL ar_wreg: got %0d expected 0", ex_wreg); end
    @(negedge clk);
    rst_n = 1;
    drive_rtype(ALUOp_sub, 5'd3, 5'd4, 5'd0, 32'h9, 32'h9);
    id_regwrite = 0; id_bne = 1; id_branch = 1;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_release_valid: got %b expected 1", ex_valid); end
    checks++; if (alu_in1 !== 32'h9) begin errors++; $display("[TB] FAIL ar_release_in1: got %h expected 9", alu_in1); end
    checks++; if (alu_bne !== 1'b1) begin errors++; $display("[TB] FAIL ar_bne: got %b expected 1", alu_bne); end
    checks++; if (ex_branch !== 1'b1) begin errors++; $display("[TB] FAIL ar_branch: got %b expected 1", ex_branch); end
    @(negedge clk);
    clear_inputs();
    tick();
    checks++; if (alu_bne !== 1'b0) begin errors++; $display("[TB] FAIL idle_bne: got %b expected 0", alu_bne); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %b expected 0", ex_valid); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_forward_priority();
    test_load_use();
    test_flush();
    test_wb_bypass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
